// File: rtl/acq_trigger_sequencer_if.sv
// Bus bundle for acq_trigger_sequencer: event inputs, configuration, and
// status outputs. The i_/o_ prefixes are from the sequencer's point of view.
interface acq_trigger_sequencer_if #(
  parameter int NUM_EVENTS    = 8,
  parameter int COUNT_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 16
);
  logic                     i_cke_tick;
  logic                     i_start;
  logic                     i_abort;
  logic [NUM_EVENTS-1:0]    i_event_in;
  logic [NUM_EVENTS-1:0]    i_start_mask;
  logic [NUM_EVENTS-1:0]    i_stop_mask;
  logic                     i_start_always;
  logic                     i_stop_always;
  logic [COUNT_WIDTH-1:0]   i_start_num;
  logic [COUNT_WIDTH-1:0]   i_stop_num;
  logic                     i_start_gate_en;
  logic                     i_stop_gate_en;
  logic                     i_start_gate;
  logic                     i_stop_gate;
  logic                     i_mem_full;
  logic [TIMEOUT_WIDTH-1:0] i_timeout_ticks;
  logic                     o_waiting;
  logic                     o_acquiring;
  logic                     o_done;
  logic [1:0]               o_done_reason;
  logic [COUNT_WIDTH-1:0]   o_stop_evt_count;

  // Side that drives events/configuration (detectors, register file).
  modport master (
    output i_cke_tick, i_start, i_abort, i_event_in, i_start_mask, i_stop_mask,
           i_start_always, i_stop_always, i_start_num, i_stop_num,
           i_start_gate_en, i_stop_gate_en, i_start_gate, i_stop_gate,
           i_mem_full, i_timeout_ticks,
    input  o_waiting, o_acquiring, o_done, o_done_reason, o_stop_evt_count
  );

  // Sequencer side.
  modport slave (
    input  i_cke_tick, i_start, i_abort, i_event_in, i_start_mask, i_stop_mask,
           i_start_always, i_stop_always, i_start_num, i_stop_num,
           i_start_gate_en, i_stop_gate_en, i_start_gate, i_stop_gate,
           i_mem_full, i_timeout_ticks,
    output o_waiting, o_acquiring, o_done, o_done_reason, o_stop_evt_count
  );
endinterface

// File: rtl/acq_trigger_sequencer.sv
// Acquisition start/stop sequencer: arm -> start gate -> wait for start
// matches -> stop gate -> acquire until stop matches / mem full / abort.
// Optional wait timeout is built only when ACQ_TIMEOUT_EN is defined.
//
// state        | meaning
// S_IDLE       | disarmed, waiting for START
// S_GATE_START | armed, waiting for START_GATE pulse
// S_WAIT       | counting start matches
// S_GATE_STOP  | start reached, waiting for STOP_GATE pulse
// S_ACQ        | acquiring, counting stop matches
module acq_trigger_sequencer #(
  parameter int NUM_EVENTS    = 8,
  parameter int COUNT_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                  i_clk_master,
  input  logic                  i_reset,
  acq_trigger_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_GATE_START = 3'd1;
  localparam logic [2:0] S_WAIT       = 3'd2;
  localparam logic [2:0] S_GATE_STOP  = 3'd3;
  localparam logic [2:0] S_ACQ        = 3'd4;

  localparam logic [1:0] R_STOP    = 2'b00;
  localparam logic [1:0] R_MEMFULL = 2'b01;
  localparam logic [1:0] R_ABORT   = 2'b10;
  localparam logic [1:0] R_TIMEOUT = 2'b11;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [2:0]             r_state;
  logic [COUNT_WIDTH-1:0] r_scount;
  logic [COUNT_WIDTH-1:0] r_ecount;
  logic [COUNT_WIDTH-1:0] r_stop_evt_count;
  logic                   r_done;
  logic [1:0]             r_done_reason;

  logic w_start_match;
  logic w_stop_match;
  logic w_arm;
  logic w_in_wait;
  logic w_timeout;

  // Event matching and arm qualification.
  always_comb begin
    w_start_match = bus.i_start_always | (|(bus.i_event_in & bus.i_start_mask));
    w_stop_match  = bus.i_stop_always  | (|(bus.i_event_in & bus.i_stop_mask));
    w_arm         = (r_state == S_IDLE) && bus.i_start && !bus.i_abort;
    w_in_wait     = (r_state == S_GATE_START) || (r_state == S_WAIT);
  end

`ifdef ACQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] r_tcount;
  logic [TIMEOUT_WIDTH-1:0] w_tcount_nxt;

  // Timeout fires on the edge where the tick count reaches TIMEOUT_TICKS.
  always_comb begin
    w_tcount_nxt = r_tcount + {{(TIMEOUT_WIDTH-1){1'b0}}, bus.i_cke_tick};
    w_timeout    = w_in_wait && (bus.i_timeout_ticks != '0) &&
                   (w_tcount_nxt == bus.i_timeout_ticks);
  end

  // Tick counter spans both waiting states; cleared only when arming.
  always_ff @(posedge i_clk_master or posedge i_reset) begin
    if (i_reset) begin
      r_tcount <= '0;
    end else if (w_arm) begin
      r_tcount <= '0;
    end else if (w_in_wait) begin
      r_tcount <= w_tcount_nxt;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^{bus.i_cke_tick, bus.i_timeout_ticks};
`endif

  // Sequencer FSM with counters, DONE pulse and termination reason.
  always_ff @(posedge i_clk_master or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_scount         <= '0;
      r_ecount         <= '0;
      r_stop_evt_count <= '0;
      r_done           <= 1'b0;
      r_done_reason    <= R_STOP;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_arm) begin
            r_scount         <= bus.i_start_num;
            r_ecount         <= bus.i_stop_num;
            r_stop_evt_count <= '0;
            r_state          <= bus.i_start_gate_en ? S_GATE_START : S_WAIT;
          end
        end
        S_GATE_START, S_WAIT: begin
          if (bus.i_abort) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b1;
            r_done_reason <= R_ABORT;
          end else if (w_timeout) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b1;
            r_done_reason <= R_TIMEOUT;
          end else if (r_state == S_GATE_START) begin
            if (bus.i_start_gate) begin
              r_state <= S_WAIT;
            end
          end else if (w_start_match) begin
            if (r_scount != '0) begin
              r_scount <= r_scount - 1'b1;
            end else begin
              r_state <= bus.i_stop_gate_en ? S_GATE_STOP : S_ACQ;
            end
          end
        end
        S_GATE_STOP: begin
          if (bus.i_abort) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b1;
            r_done_reason <= R_ABORT;
          end else if (bus.i_stop_gate) begin
            r_state <= S_ACQ;
          end
        end
        S_ACQ: begin
          if (bus.i_abort) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b1;
            r_done_reason <= R_ABORT;
          end else if (bus.i_mem_full) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b1;
            r_done_reason <= R_MEMFULL;
          end else if (w_stop_match) begin
            if (r_stop_evt_count != CNT_MAX) begin
              r_stop_evt_count <= r_stop_evt_count + 1'b1;
            end
            if (r_ecount != '0) begin
              r_ecount <= r_ecount - 1'b1;
            end else begin
              r_state       <= S_IDLE;
              r_done        <= 1'b1;
              r_done_reason <= R_STOP;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_waiting        = w_in_wait;
  assign bus.o_acquiring      = (r_state == S_GATE_STOP) || (r_state == S_ACQ);
  assign bus.o_done           = r_done;
  assign bus.o_done_reason    = r_done_reason;
  assign bus.o_stop_evt_count = r_stop_evt_count;

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// Bench for acq_trigger_sequencer: directed scenarios followed by random
// stimulus, all checked by a per-cycle scoreboard fed from a reference model.
module tb_acq_trigger_sequencer;
  localparam int NE = 8;
  localparam int CW = 8;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  acq_trigger_sequencer_if #(.NUM_EVENTS(NE), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) bus ();

  acq_trigger_sequencer #(.NUM_EVENTS(NE), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
    .i_clk_master(clk),
    .i_reset     (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic          waiting;
    logic          acquiring;
    logic          done;
    logic [1:0]    reason;
    logic [CW-1:0] count;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a sequence is "busy" once armed; it is either still
  // looking for its start or already acquiring, possibly held for a gate.
  bit m_busy, m_in_acq, m_gate_wait, m_done;
  int m_start_left, m_stop_left, m_stop_seen, m_ticks, m_reason;

  function automatic exp_t m_out();
    exp_t e;
    e.waiting   = m_busy && !m_in_acq;
    e.acquiring = m_busy && m_in_acq;
    e.done      = m_done;
    e.reason    = 2'(m_reason);
    e.count     = CW'(m_stop_seen);
    return e;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_in_acq = 0; m_gate_wait = 0; m_done = 0;
    m_start_left = 0; m_stop_left = 0; m_stop_seen = 0; m_ticks = 0; m_reason = 0;
  endtask

  task automatic m_finish(input int r);
    m_busy = 0; m_done = 1; m_reason = r;
  endtask

  task automatic m_step();
    bit smatch, pmatch, tmo;
    smatch = bus.i_start_always || ((bus.i_event_in & bus.i_start_mask) != 0);
    pmatch = bus.i_stop_always  || ((bus.i_event_in & bus.i_stop_mask) != 0);
    tmo = 0;
    m_done = 0;
    if (!m_busy) begin
      if (bus.i_start && !bus.i_abort) begin
        m_busy = 1; m_in_acq = 0; m_gate_wait = bus.i_start_gate_en;
        m_start_left = int'(bus.i_start_num); m_stop_left = int'(bus.i_stop_num);
        m_stop_seen = 0; m_ticks = 0;
      end
    end else if (bus.i_abort) begin
      m_finish(2);
    end else if (!m_in_acq) begin
`ifdef ACQ_TIMEOUT_EN
      m_ticks = (m_ticks + int'(bus.i_cke_tick)) % (1 << TW);
      tmo = (bus.i_timeout_ticks != 0) && (m_ticks == int'(bus.i_timeout_ticks));
`endif
      if (tmo) m_finish(3);
      else if (m_gate_wait) begin
        if (bus.i_start_gate) m_gate_wait = 0;
      end else if (smatch) begin
        if (m_start_left > 0) m_start_left--;
        else begin m_in_acq = 1; m_gate_wait = bus.i_stop_gate_en; end
      end
    end else begin
      if (m_gate_wait) begin
        if (bus.i_stop_gate) m_gate_wait = 0;
      end else if (bus.i_mem_full) m_finish(1);
      else if (pmatch) begin
        if (m_stop_seen < (1 << CW) - 1) m_stop_seen++;
        if (m_stop_left > 0) m_stop_left--;
        else m_finish(0);
      end
    end
  endtask

  // Model advances on every clock edge; expected outputs go to the scoreboard.
  always @(posedge clk) begin
    if (rst) m_reset();
    else m_step();
    exp_q.push_back(m_out());
  end

  // Asynchronous reset between edges overrides the pending expectation.
  always @(posedge rst) begin
    m_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = m_out();
  end

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.o_waiting, bus.o_acquiring, bus.o_done, bus.o_done_reason, bus.o_stop_evt_count};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t actual w=%b a=%b d=%b r=%0d c=%0d required w=%b a=%b d=%b r=%0d c=%0d",
                 $time, a.waiting, a.acquiring, a.done, a.reason, a.count,
                 e.waiting, e.acquiring, e.done, e.reason, e.count);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    bus.i_cke_tick = 0; bus.i_start = 0; bus.i_abort = 0; bus.i_event_in = '0;
    bus.i_start_gate = 0; bus.i_stop_gate = 0; bus.i_mem_full = 0;
  endtask

  task automatic pulse_ev(input int i);
    bus.i_event_in = '0;
    bus.i_event_in[i] = 1'b1;
    @(negedge clk);
    bus.i_event_in = '0;
  endtask

  task automatic arm();
    bus.i_start = 1;
    @(negedge clk);
    bus.i_start = 0;
  endtask

  initial begin
    clr_inputs();
    bus.i_start_mask = '0; bus.i_stop_mask = '0;
    bus.i_start_always = 0; bus.i_stop_always = 0;
    bus.i_start_num = '0; bus.i_stop_num = '0;
    bus.i_start_gate_en = 0; bus.i_stop_gate_en = 0;
    bus.i_timeout_ticks = '0;

    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_waiting", bus.o_waiting, 0);
    chk("reset_reason", bus.o_done_reason, 0);
    rst = 0;
    @(negedge clk);

    // Start after 3rd match, stop after 2nd stop match.
    bus.i_start_mask = 8'h01; bus.i_stop_mask = 8'h01;
    bus.i_start_num = 8'd2; bus.i_stop_num = 8'd1;
    arm();
    chk("t1_waiting", bus.o_waiting, 1);
    pulse_ev(0); pulse_ev(0);
    chk("t1_not_acq_after_2nd", bus.o_acquiring, 0);
    pulse_ev(0);
    chk("t1_acq_after_3rd", bus.o_acquiring, 1);
    pulse_ev(0);
    chk("t1_acq_after_4th", bus.o_acquiring, 1);
    pulse_ev(0);
    chk("t1_done", bus.o_done, 1);
    chk("t1_reason", bus.o_done_reason, 0);
    chk("t1_count", bus.o_stop_evt_count, 2);
    chk("t1_idle", bus.o_acquiring, 0);
    pulse_ev(0);
    chk("t1_done_one_cycle", bus.o_done, 0);
    chk("t1_6th_ignored", bus.o_waiting, 0);

    // Start gate holds off start matching.
    bus.i_start_mask = 8'h02; bus.i_stop_mask = 8'h02;
    bus.i_start_num = 8'd0; bus.i_stop_num = 8'd0;
    bus.i_start_gate_en = 1;
    arm();
    pulse_ev(1);
    chk("t2_ev_ignored_in_gate", bus.o_acquiring, 0);
    bus.i_start_gate = 1;
    @(negedge clk);
    bus.i_start_gate = 0;
    chk("t2_waiting_after_gate", bus.o_waiting, 1);
    pulse_ev(1);
    chk("t2_acq", bus.o_acquiring, 1);

    // Mem full beats a final stop match.
    bus.i_mem_full = 1; bus.i_event_in = 8'h02;
    @(negedge clk);
    clr_inputs();
    chk("t3_done", bus.o_done, 1);
    chk("t3_reason_memfull", bus.o_done_reason, 1);
    chk("t3_count", bus.o_stop_evt_count, 0);

    // Abort from stop gate; abort in idle; start blocked by abort.
    bus.i_start_gate_en = 0; bus.i_stop_gate_en = 1;
    arm();
    pulse_ev(1);
    chk("t4_in_gate_stop", bus.o_acquiring, 1);
    bus.i_abort = 1;
    @(negedge clk);
    bus.i_abort = 0;
    chk("t4_done", bus.o_done, 1);
    chk("t4_reason_abort", bus.o_done_reason, 2);
    chk("t4_idle", bus.o_acquiring, 0);
    @(negedge clk);
    chk("t4_done_low", bus.o_done, 0);
    bus.i_abort = 1;
    @(negedge clk);
    chk("t4_abort_idle_no_done", bus.o_done, 0);
    bus.i_start = 1;
    @(negedge clk);
    chk("t4_start_blocked", bus.o_waiting, 0);
    bus.i_start = 0; bus.i_abort = 0;
    @(negedge clk);

    // Timeout: 3 ticks, one every 4 cycles, no events.
    bus.i_stop_gate_en = 0; bus.i_start_mask = '0;
    bus.i_timeout_ticks = 16'd3;
    arm();
    for (int k = 1; k <= 3; k++) begin
      repeat (3) @(negedge clk);
      bus.i_cke_tick = 1;
      @(negedge clk);
      bus.i_cke_tick = 0;
      if (k == 2) chk("t5_still_waiting_2nd_tick", bus.o_waiting, 1);
    end
`ifdef ACQ_TIMEOUT_EN
    chk("t5_timeout_done", bus.o_done, 1);
    chk("t5_timeout_reason", bus.o_done_reason, 3);
    bus.i_timeout_ticks = '0;
    arm();
    for (int k = 0; k < 8; k++) begin
      repeat (3) @(negedge clk);
      bus.i_cke_tick = 1;
      @(negedge clk);
      bus.i_cke_tick = 0;
    end
    chk("t5_zero_waits", bus.o_waiting, 1);
`else
    chk("t5_no_timeout_waiting", bus.o_waiting, 1);
    chk("t5_no_timeout_done", bus.o_done, 0);
`endif
    bus.i_abort = 1;
    @(negedge clk);
    bus.i_abort = 0;
    @(negedge clk);

    // Asynchronous reset mid-acquisition.
    bus.i_start_mask = 8'h02; bus.i_stop_mask = 8'h02;
    bus.i_start_num = 8'd0; bus.i_stop_num = 8'd3;
    arm();
    pulse_ev(1); pulse_ev(1); pulse_ev(1);
    chk("t6_count_before_reset", bus.o_stop_evt_count, 2);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("t6_rst_acq", bus.o_acquiring, 0);
    chk("t6_rst_count", bus.o_stop_evt_count, 0);
    chk("t6_rst_done", bus.o_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    arm();
    chk("t6_fresh_waiting", bus.o_waiting, 1);
    chk("t6_no_done", bus.o_done, 0);
    bus.i_abort = 1;
    @(negedge clk);
    bus.i_abort = 0;

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        bus.i_start_mask    = NE'($urandom);
        bus.i_stop_mask     = NE'($urandom);
        bus.i_start_num     = CW'($urandom_range(0, 3));
        bus.i_stop_num      = CW'($urandom_range(0, 3));
        bus.i_start_gate_en = ($urandom_range(0, 2) == 0);
        bus.i_stop_gate_en  = ($urandom_range(0, 2) == 0);
        bus.i_start_always  = ($urandom_range(0, 9) == 0);
        bus.i_stop_always   = ($urandom_range(0, 9) == 0);
        bus.i_timeout_ticks = TW'($urandom_range(0, 5));
      end
      bus.i_start      = ($urandom_range(0, 7) == 0);
      bus.i_abort      = ($urandom_range(0, 49) == 0);
      bus.i_start_gate = ($urandom_range(0, 5) == 0);
      bus.i_stop_gate  = ($urandom_range(0, 5) == 0);
      bus.i_mem_full   = ($urandom_range(0, 39) == 0);
      bus.i_cke_tick   = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < NE; b++) bus.i_event_in[b] = ($urandom_range(0, 11) == 0);
      @(negedge clk);
    end

    clr_inputs();
    bus.i_abort = 1;
    @(negedge clk);
    bus.i_abort = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/acq_trigger_sequencer.md
# acq_trigger_sequencer

Parametrised acquisition start/stop sequencer for the disc-capture datapath. It consumes NUM_EVENTS single-cycle event pulses already synchronised to CLK_MASTER: index, per-channel sync-word detects, and others. It runs the arm → gate → wait → gate → acquire sequence with programmable event masks and counts. It adds a wait timeout, a termination-reason report and a stop-event count, and sits between the event detectors and the capture RAM write controller.

## Interface
- NUM_EVENTS, 8, number of event inputs (1..32)
- COUNT_WIDTH, 8, width of start/stop event counters
- TIMEOUT_WIDTH, 16, width of timeout tick counter
- CLK_MASTER  in  1  master clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- CKE_TICK  in  1  timebase clock enable for timeout (one CLK_MASTER cycle wide)
- START  in  1  arm request, level, sampled in IDLE only
- ABORT  in  1  synchronous abort, level
- EVENT_IN  in  NUM_EVENTS  event pulses, one cycle wide
- START_MASK, STOP_MASK  in  NUM_EVENTS  event enables for start/stop matching
- START_ALWAYS, STOP_ALWAYS  in  1  treat every cycle as a match
- START_NUM, STOP_NUM  in  COUNT_WIDTH  matches to skip before start/stop
- START_GATE_EN, STOP_GATE_EN  in  1  require gate pulse before waiting/acquiring
- START_GATE, STOP_GATE  in  1  gate pulses (track-mark detects)
- MEM_FULL  in  1  capture RAM full
- TIMEOUT_TICKS  in  TIMEOUT_WIDTH  wait timeout in CKE_TICK units; 0 = disabled
- WAITING  out  1  in S_GATE_START or S_WAIT
- ACQUIRING  out  1  in S_GATE_STOP or S_ACQ
- DONE  out  1  one-cycle pulse on return to IDLE from any non-IDLE state
- DONE_REASON  out  2  00 stop count, 01 mem full, 10 abort, 11 timeout; held until next DONE
- STOP_EVT_COUNT  out  COUNT_WIDTH  stop matches seen in S_ACQ, saturating

## Operation
- start_match = START_ALWAYS | |(EVENT_IN & START_MASK). stop_match is formed the same way from STOP_ALWAYS and STOP_MASK.
- States: S_IDLE, S_GATE_START, S_WAIT, S_GATE_STOP, S_ACQ. An unreachable encoding goes to S_IDLE with no DONE.
- S_IDLE:
  - START=1 loads scount←START_NUM, ecount←STOP_NUM and clears STOP_EVT_COUNT and the timeout counter.
  - It then goes to S_GATE_START if START_GATE_EN, else to S_WAIT.
- S_GATE_START: on START_GATE go to S_WAIT. Events are ignored.
- S_WAIT, on start_match:
  - scount≠0: scount decrements and the block stays in S_WAIT.
  - scount=0: go to S_GATE_STOP if STOP_GATE_EN, else S_ACQ.
  - START_NUM=N therefore starts on the (N+1)th match.
- S_GATE_STOP: on STOP_GATE go to S_ACQ. Stop matches are ignored and not counted.
- S_ACQ, in priority order:
  - MEM_FULL: go to IDLE with reason 01.
  - stop_match: STOP_EVT_COUNT increments (saturating at all-ones). If ecount≠0, ecount decrements; if ecount=0, go to IDLE with reason 00.
- ABORT has the highest priority in every state. From non-IDLE it goes to IDLE with DONE and reason 10. In IDLE it has no effect; START is ignored while ABORT=1.
- START held high after completion re-arms on the cycle after DONE. This is deliberate: software clears START.
- Counters are unsigned COUNT_WIDTH. Decrement happens only when the count is nonzero, so there is no wrap.

## Timing
- RESET values: state S_IDLE; WAITING=0, ACQUIRING=0, DONE=0, DONE_REASON=00, STOP_EVT_COUNT=0; scount, ecount and the timeout counter all 0.
- All outputs are registered. WAITING/ACQUIRING decode the registered state.
- Latency is one clock edge:
  - START high at edge k gives WAITING=1 after edge k.
  - An event or gate pulse at edge k moves the state after edge k.
- DONE is high for exactly the cycle in which the state first reads S_IDLE. DONE_REASON updates on the same edge.
- Simultaneous events:
  - Several mask bits matching in one cycle count as one match.
  - A gate pulse and a match in the same cycle: only the gate transition is taken; the match is not counted.
  - MEM_FULL and a final stop_match together: reason 01.

## Configuration
- ACQ_TIMEOUT_EN defined:
  - A TIMEOUT_WIDTH tick counter increments on CKE_TICK while in S_GATE_START or S_WAIT. It is not cleared between those two states.
  - When it equals a nonzero TIMEOUT_TICKS, the block goes to IDLE with DONE and reason 11.
  - If a match, gate or ABORT falls in the same cycle, ABORT wins first, then the timeout.
- ACQ_TIMEOUT_EN undefined:
  - No tick counter is built. CKE_TICK and TIMEOUT_TICKS are ignored.
  - Reason 11 is never produced, and waiting is unbounded.

## Test plan
- START_MASK=0x01, START_NUM=2, STOP_MASK=0x01, STOP_NUM=1, pulse EVENT_IN[0] six times → ACQUIRING from after the 3rd pulse until after the 5th; DONE pulse, DONE_REASON=00, STOP_EVT_COUNT=2.
- START_GATE_EN=1, EVENT_IN[1] pulses before START_GATE → ignored; after START_GATE, the first masked pulse (START_NUM=0) → ACQUIRING next cycle.
- In S_ACQ with STOP_NUM=0, MEM_FULL and stop_match in the same cycle → IDLE, DONE_REASON=01, STOP_EVT_COUNT=0.
- ABORT asserted in S_GATE_STOP → IDLE next cycle, DONE=1 for one cycle, DONE_REASON=10; ABORT in IDLE → no DONE.
- With ACQ_TIMEOUT_EN: TIMEOUT_TICKS=3, no events, CKE_TICK every 4 cycles → DONE with reason 11 on the 3rd tick. TIMEOUT_TICKS=0 → waits indefinitely.
- RESET asserted mid-S_ACQ, asynchronously → all outputs 0 immediately, no DONE pulse; START after release begins a fresh sequence.
